// File: rtl/core_periph_router.sv
// core_periph_router: address-decoded core-to-peripheral router with in-order outstanding tracking and an error slave.
// Optional saturating perf counters enabled by CORE_ROUTER_PERF_EN.
module core_periph_router #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NB_TARGETS      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   region_base_i [NB_TARGETS],
    input  logic [ADDR_WIDTH-1:0]   region_mask_i [NB_TARGETS],
    input  logic                    core_req_i,
    input  logic [ADDR_WIDTH-1:0]   core_add_i,
    input  logic                    core_wen_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] core_be_i,
    output logic                    core_gnt_o,
    output logic                    core_r_valid_o,
    output logic [DATA_WIDTH-1:0]   core_r_rdata_o,
    output logic                    core_r_opc_o,
    output logic [NB_TARGETS-1:0]   tgt_req_o,
    output logic [ADDR_WIDTH-1:0]   tgt_add_o [NB_TARGETS],
    output logic [NB_TARGETS-1:0]   tgt_wen_o,
    output logic [DATA_WIDTH-1:0]   tgt_wdata_o [NB_TARGETS],
    output logic [DATA_WIDTH/8-1:0] tgt_be_o [NB_TARGETS],
    input  logic [NB_TARGETS-1:0]   tgt_gnt_i,
    input  logic [NB_TARGETS-1:0]   tgt_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   tgt_r_rdata_i [NB_TARGETS],
    input  logic [NB_TARGETS-1:0]   tgt_r_opc_i,
    input  logic                    perf_clear_i,
    output logic [31:0]             perf_contention_o,
    output logic [31:0]             perf_hazard_o
);
    localparam logic [4:0] ERR = 5'(NB_TARGETS);
    localparam logic [3:0] MAX = 4'(MAX_OUTSTANDING);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADACCE5);

    logic [3:0] cnt, cnt_e;
    logic [4:0] cur_tgt, cur_e, dec;
    logic       err_pend, allowed, sel_gnt;

    // Registered state is masked during reset so outputs behave as if cnt were already 0.
    always_comb begin
        cnt_e = rst_ni ? cnt : 4'd0;
        cur_e = rst_ni ? cur_tgt : 5'd0;
        dec = ERR;
        for (int i = NB_TARGETS - 1; i >= 0; i--)
            if ((core_add_i & region_mask_i[i]) == (region_base_i[i] & region_mask_i[i])) dec = 5'(i);
        allowed = core_req_i && cnt_e < MAX && (cnt_e == 4'd0 || dec == cur_e);
        sel_gnt = dec == ERR;
        core_r_valid_o = cnt_e != 4'd0 && cur_e == ERR && err_pend;
        core_r_rdata_o = ERR_DATA;
        core_r_opc_o = 1'b1;
        tgt_req_o = '0;
        tgt_wen_o = '0;
        for (int i = 0; i < NB_TARGETS; i++) begin
            tgt_add_o[i] = core_add_i;
            tgt_wen_o[i] = core_wen_i;
            tgt_wdata_o[i] = core_wdata_i;
            tgt_be_o[i] = core_be_i;
            tgt_req_o[i] = allowed && dec == 5'(i);
            if (dec == 5'(i)) sel_gnt = tgt_gnt_i[i];
            if (cur_e == 5'(i)) begin
                core_r_valid_o = cnt_e != 4'd0 && tgt_r_valid_i[i];
                core_r_rdata_o = tgt_r_rdata_i[i];
                core_r_opc_o = tgt_r_opc_i[i];
            end
        end
        core_gnt_o = allowed && sel_gnt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= 4'd0;
            cur_tgt <= 5'd0;
            err_pend <= 1'b0;
        end else begin
            cnt <= cnt + 4'(core_gnt_o) - 4'(core_r_valid_o);
            if (core_gnt_o) cur_tgt <= dec;
            err_pend <= core_gnt_o && dec == ERR;
        end
    end

`ifdef CORE_ROUTER_PERF_EN
    logic [31:0] cont_q, haz_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || perf_clear_i) begin
            cont_q <= '0;
            haz_q <= '0;
        end else begin
            if (allowed && !sel_gnt && cont_q != '1) cont_q <= cont_q + 32'd1;
            if (core_req_i && !allowed && haz_q != '1) haz_q <= haz_q + 32'd1;
        end
    end

    assign perf_contention_o = cont_q;
    assign perf_hazard_o = haz_q;
`else
    logic unused_perf;
    assign unused_perf = perf_clear_i;
    assign perf_contention_o = '0;
    assign perf_hazard_o = '0;
`endif
endmodule
